// File: rtl/div_radix2_axis.sv
// Multi-cycle radix-2 restoring divider with an AXI-stream-style handshake.
// One division in flight: accept, 32 iteration steps, sign fix, one-cycle result pulse.
// Result layout: [63:32] quotient, [31:0] remainder.
module div_radix2_axis #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_divisor_tvalid,
  input  logic [31:0] s_axis_divisor_tdata,
  input  logic        s_axis_dividend_tvalid,
  input  logic [31:0] s_axis_dividend_tdata,
  output logic        s_axis_tready,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dsr;
  logic        sa;
  logic        sb;

  logic        accept;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] trial;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign accept             = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
  assign s_axis_tready      = (state == IDLE);
  assign m_axis_dout_tvalid = (state == DONE);

  // Operand magnitudes, trial subtraction and sign correction.
  // The partial remainder never reaches dsr, so its bit 32 is always zero
  // and only the low 32 bits are kept in the register.
  always_comb begin
    a_neg = SIGNED && s_axis_dividend_tdata[31];
    b_neg = SIGNED && s_axis_divisor_tdata[31];
    mag_a = a_neg ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
    mag_b = b_neg ? (32'd0 - s_axis_divisor_tdata)  : s_axis_divisor_tdata;
    trial = {rem, quo[31]} - {1'b0, dsr};
    q_fix = (sa ^ sb) ? (32'd0 - quo) : quo;
    r_fix = sa ? (32'd0 - rem) : rem;
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, 32 steps in ITER, then FIX and a one-cycle DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ITER;
      ITER:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iteration and result register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cnt               <= '0;
      rem               <= '0;
      quo               <= '0;
      dsr               <= '0;
      sa                <= 1'b0;
      sb                <= 1'b0;
      m_axis_dout_tdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            rem <= '0;
            quo <= mag_a;
            dsr <= mag_b;
            sa  <= a_neg;
            sb  <= b_neg;
          end
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (!trial[32]) begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= {rem[30:0], quo[31]};
            quo <= {quo[30:0], 1'b0};
          end
        end
        FIX: m_axis_dout_tdata <= {q_fix, r_fix};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_radix2_axis.sv
// Self-checking bench: a signed and an unsigned instance share the operand bus;
// expected results are queued at accept and compared when each instance pulses tvalid.
module tb_div_radix2_axis;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        dvs_valid = 1'b0;
  logic [31:0] dvs_data = '0;
  logic        dnd_valid = 1'b0;
  logic [31:0] dnd_data = '0;
  logic        tready_s, tready_u;
  logic        tvalid_s, tvalid_u;
  logic [63:0] tdata_s, tdata_u;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = -1;
  logic [63:0] exp_s[$];
  logic [63:0] exp_u[$];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  div_radix2_axis #(.SIGNED(1'b1)) u_s (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tdata(dvs_data),
    .s_axis_dividend_tvalid(dnd_valid), .s_axis_dividend_tdata(dnd_data),
    .s_axis_tready(tready_s), .m_axis_dout_tvalid(tvalid_s), .m_axis_dout_tdata(tdata_s)
  );

  div_radix2_axis #(.SIGNED(1'b0)) u_u (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_divisor_tvalid(dvs_valid), .s_axis_divisor_tdata(dvs_data),
    .s_axis_dividend_tvalid(dnd_valid), .s_axis_dividend_tdata(dnd_data),
    .s_axis_tready(tready_u), .m_axis_dout_tvalid(tvalid_u), .m_axis_dout_tdata(tdata_u)
  );

  // Reference models built on language division semantics plus the documented corner cases.
  function automatic logic [63:0] model_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    return {a / b, a % b};
  endfunction

  function automatic logic [63:0] model_s(input logic [31:0] a, input logic [31:0] b);
    int ai, bi, qi, ri;
    if (b == 32'd0) return {(a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF), a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    ai = a;
    bi = b;
    qi = ai / bi;
    ri = ai % bi;
    return {qi[31:0], ri[31:0]};
  endfunction

  // Result monitor: every tvalid pulse must match the oldest queued expectation.
  always @(posedge aclk) begin
    logic [63:0] e;
    #1;
    if (tvalid_s) begin
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL spurious_tvalid_s got %h required no pulse", tdata_s);
      end else begin
        e = exp_s.pop_front();
        if (tdata_s !== e) begin
          errors++;
          $display("FAIL result_s got %h required %h", tdata_s, e);
        end
      end
    end
    if (tvalid_u) begin
      checks++;
      if (exp_u.size() == 0) begin
        errors++;
        $display("FAIL spurious_tvalid_u got %h required no pulse", tdata_u);
      end else begin
        e = exp_u.pop_front();
        if (tdata_u !== e) begin
          errors++;
          $display("FAIL result_u got %h required %h", tdata_u, e);
        end
      end
    end
  end

  // Wait for both instances ready, present one operand pair for exactly one edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
    int n = 0;
    while (!(tready_s && tready_u) && n < 64) begin
      @(posedge aclk); #1; n++;
    end
    if (n >= 64) begin
      checks++; errors++;
      $display("FAIL issue_timeout got tready %b%b required 11", tready_s, tready_u);
    end
    dnd_data = a; dvs_data = b;
    dnd_valid = 1'b1; dvs_valid = 1'b1;
    if (push) begin
      exp_s.push_back(model_s(a, b));
      exp_u.push_back(model_u(a, b));
    end
    @(posedge aclk);
    last_accept = cyc;
    #1;
    dnd_valid = 1'b0; dvs_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_s.size() != 0 || exp_u.size() != 0) && n < 100) begin
      @(posedge aclk); #1; n++;
    end
    checks++;
    if (exp_s.size() != 0 || exp_u.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending %0d/%0d required 0/0", exp_s.size(), exp_u.size());
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({tready_s, tready_u, tvalid_s, tvalid_u} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_flags got %b required 1100", {tready_s, tready_u, tvalid_s, tvalid_u});
    end
    checks++;
    if (tdata_s !== 64'h0 || tdata_u !== 64'h0) begin
      errors++;
      $display("FAIL reset_tdata got %h/%h required 0/0", tdata_s, tdata_u);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic test_latency();
    int n = 0;
    bit low_ok = 1'b1;
    issue(32'd100, 32'd7, 1'b1);
    while (!tvalid_u && n < 40) begin
      if (tready_u || tready_s) low_ok = 1'b0;
      @(posedge aclk); #1; n++;
    end
    if (tready_u || tready_s) low_ok = 1'b0;
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL latency got %0d edges required 33", n);
    end
    checks++;
    if (!low_ok) begin
      errors++;
      $display("FAIL tready_busy got high required low through DONE");
    end
    checks++;
    if (tdata_u !== {32'd14, 32'd2}) begin
      errors++;
      $display("FAIL unsigned_100_7 got %h required %h", tdata_u, {32'd14, 32'd2});
    end
    wait_drain();
  endtask

  task automatic test_corners();
    logic [31:0] ta[8] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF,
                           32'd7, 32'hFFFF_FFF9, 32'd0, 32'h8000_0000};
    logic [31:0] tb_[8] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1,
                            32'd0, 32'd0, 32'd5, 32'd1};
    for (int i = 0; i < 8; i++) issue(ta[i], tb_[i], 1'b1);
    wait_drain();
    checks++;
    if (tdata_s !== 64'h8000_0000_0000_0000) begin
      errors++;
      $display("FAIL signed_min_by_1 got %h required 8000000000000000", tdata_s);
    end
  endtask

  task automatic test_handshake();
    bit held = 1'b1;
    dnd_valid = 1'b1; dnd_data = 32'd55; dvs_data = 32'd5;
    repeat (5) begin
      @(posedge aclk); #1;
      if (!tready_s || !tready_u) held = 1'b0;
    end
    dnd_valid = 1'b0;
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL half_valid_accept got tready low required stay high");
    end
    issue(32'd1000, 32'd10, 1'b1);
    repeat (4) begin
      @(posedge aclk); #1;
    end
    dnd_valid = 1'b1; dvs_valid = 1'b1; dnd_data = 32'd9; dvs_data = 32'd3;
    repeat (6) begin
      @(posedge aclk); #1;
    end
    dnd_valid = 1'b0; dvs_valid = 1'b0;
    wait_drain();
    repeat (40) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    issue(32'd123456, 32'd789, 1'b0);
    repeat (8) begin
      @(posedge aclk); #1;
    end
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    checks++;
    if (tdata_s !== 64'h0 || tdata_u !== 64'h0) begin
      errors++;
      $display("FAIL abort_tdata got %h/%h required 0/0", tdata_s, tdata_u);
    end
    checks++;
    if ({tready_s, tready_u, tvalid_s, tvalid_u} !== 4'b1100) begin
      errors++;
      $display("FAIL abort_flags got %b required 1100", {tready_s, tready_u, tvalid_s, tvalid_u});
    end
    repeat (40) begin
      @(posedge aclk); #1;
    end
    issue(32'hFFFF_FF9C, 32'd9, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int prev;
    logic [31:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'd0) b = 32'd1;
      prev = last_accept;
      issue(a, b, 1'b1);
      if (i > 0) begin
        checks++;
        if (last_accept - prev !== 35) begin
          errors++;
          $display("FAIL throughput got %0d cycles required 35", last_accept - prev);
        end
      end
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_handshake();
    test_reset_mid_op();
    test_back_to_back();
    repeat (5) begin
      @(posedge aclk); #1;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
